// File: rtl/alu_shift_unit_pkg.sv
// Shared op codes and helpers for the pipelined shift/rotate unit.
package alu_shift_unit_pkg;

  localparam int unsigned OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_ROR  = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_ROL  = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_SHRA = 3'd4;

  function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
    return op <= OP_SHRA;
  endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// Combinational barrel slice: applies count bits [HI_BIT:LO_BIT] for the given op.
module alu_shift_stage
  import alu_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LO_BIT     = 0,
  parameter int unsigned HI_BIT     = 0
) (
  input  logic [OP_WIDTH-1:0]      op,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [HI_BIT-LO_BIT:0]   cnt,
  output logic [DATA_WIDTH-1:0]    data_out
);

  localparam int unsigned NBITS = HI_BIT - LO_BIT + 1;

  logic [DATA_WIDTH-1:0] chain [NBITS+1];

  assign chain[0] = data_in;
  assign data_out = chain[NBITS];

  // One conditional fixed-distance step per count bit; illegal ops pass through.
  for (genvar g = 0; g < NBITS; g++) begin : g_bit
    localparam int unsigned AMT = 1 << (LO_BIT + g);
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;

    assign x = chain[g];

    always_comb begin
      y = x;
      if (cnt[g]) begin
        case (op)
          OP_ROR:  y = (x >> AMT) | (x << (DATA_WIDTH - AMT));
          OP_ROL:  y = (x << AMT) | (x >> (DATA_WIDTH - AMT));
          OP_SHR:  y = x >> AMT;
          OP_SHL:  y = x << AMT;
          OP_SHRA: y = $unsigned($signed(x) >>> AMT);
          default: y = x;
        endcase
      end
    end

    assign chain[g+1] = y;
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Two-stage pipelined shift/rotate unit with valid/ready handshake and carry/zero/error flags.
module alu_shift_unit
  import alu_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_WIDTH-1:0]    in_op,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_carry,
  output logic                   out_zero,
  output logic                   out_err
);

  localparam int unsigned SPLIT = SHAMT_WIDTH / 2;

  logic                   s1_valid;
  logic [OP_WIDTH-1:0]    s1_op;
  logic [SHAMT_WIDTH-1:0] s1_shamt;
  logic [DATA_WIDTH-1:0]  s1_orig;
  logic [DATA_WIDTH-1:0]  s1_data;
  logic [DATA_WIDTH-1:0]  s1_next;
  logic [DATA_WIDTH-1:0]  s2_next;
  logic                   adv1;
  logic                   adv2;
  logic                   carry_c;
  logic                   err_c;
  logic [SHAMT_WIDTH-1:0] lo_idx;
  logic [SHAMT_WIDTH-1:0] hi_idx;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  alu_shift_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .LO_BIT     (SPLIT),
    .HI_BIT     (SHAMT_WIDTH - 1)
  ) u_stage_hi (
    .op       (in_op),
    .data_in  (in_data),
    .cnt      (in_shamt[SHAMT_WIDTH-1:SPLIT]),
    .data_out (s1_next)
  );

  alu_shift_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .LO_BIT     (0),
    .HI_BIT     (SPLIT - 1)
  ) u_stage_lo (
    .op       (s1_op),
    .data_in  (s1_data),
    .cnt      (s1_shamt[SPLIT-1:0]),
    .data_out (s2_next)
  );

  // Carry picks the last bit to leave the word; n-1 and W-n wrap naturally in SHAMT_WIDTH bits.
  always_comb begin
    carry_c = 1'b0;
    err_c   = !op_is_legal(s1_op);
    lo_idx  = s1_shamt - SHAMT_WIDTH'(1);
    hi_idx  = SHAMT_WIDTH'(0) - s1_shamt;
    if (s1_shamt != '0) begin
      case (s1_op)
        OP_ROR:  carry_c = s2_next[DATA_WIDTH-1];
        OP_ROL:  carry_c = s2_next[0];
        OP_SHR:  carry_c = s1_orig[lo_idx];
        OP_SHRA: carry_c = s1_orig[lo_idx];
        OP_SHL:  carry_c = s1_orig[hi_idx];
        default: carry_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_shamt  <= '0;
      s1_orig   <= '0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op    <= in_op;
          s1_shamt <= in_shamt;
          s1_orig  <= in_data;
          s1_data  <= s1_next;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= s2_next;
          out_carry <= carry_c;
          out_zero  <= (s2_next == '0);
          out_err   <= err_c;
        end
      end
    end
  end

endmodule
